load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage placed directly upstream of `data_cache`. It accepts one load or store per transaction from the execute stage, drives the cache's word-wide combinational read/write port, and returns sign- or zero-extended load data with its destination tag. Sub-word stores are done by read-modify-write, so the cache only ever sees aligned 32-bit accesses.

## Interface
- `CACHE_OFFSET`, default `` `_DATA_CACHE_OFFSET ``: base address of the cache window. Passed through for bench checks only; the block does not subtract it.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `i_valid`, in, 1: request valid from execute.
- `o_ready`, out, 1: `state==IDLE`. Equals 1 during reset.
- `i_op`, in, 1: 0 = load, 1 = store.
- `i_funct3`, in, 3: RISC-V width code.
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- `i_address`, in, 32: byte address.
- `i_store_val`, in, 32: store data, right-justified.
- `i_rd`, in, 5: destination register tag.
- `o_valid`, out, 1: one-cycle response pulse.
- `o_load_val`, out, 32: extended load result. 0 for stores and dropped requests.
- `o_rd`, out, 5: tag latched at accept.
- `o_misaligned`, out, 1: misalignment flag, qualified by `o_valid`.
- `cache_address`, out, 32: `{addr_q[31:2],2'b00}`.
- `cache_i_val`, out, 32: full word to write.
- `cache_op_type`, out, 1: 0 read, 1 write. Equals 1 only in state WRITE.
- `cache_o_val`, in, 32: combinational read data from the cache.

## Operation
- **FSM states:** IDLE, READ, WRITE, RESP.
  - IDLE → READ: load, or SB/SH.
  - IDLE → WRITE: SW.
  - IDLE → RESP: dropped or misaligned request.
  - READ → RESP: load.
  - READ → WRITE: SB/SH.
  - WRITE → RESP.
  - RESP → IDLE, always.
- **Accept:** occurs when `i_valid && o_ready` at a rising edge. Latch op, funct3, address, store value and rd.
- **READ:** `cache_op_type=0`. Capture `cache_o_val` into `word_q` at the end of the cycle.
- **Load extract:** byte lane = `addr_q[1:0]`; half lane = `addr_q[1]`.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- **Store merge:** replace the addressed byte/half of `word_q` with `i_store_val[7:0]` or `[15:0]`. Other bytes are unchanged. SW writes `i_store_val` directly.
- **Unsupported funct3:** loads 011/110/111; stores ≥011.
  - No cache access.
  - RESP with `o_load_val=0`, `o_misaligned=0`.
- **Idle outputs:** outside WRITE, `cache_op_type=0` and `cache_i_val=0`.
- **Reset:**
  - State → IDLE; all registers → 0.
  - `o_valid=0`, `o_load_val=0`, `o_rd=0`, `o_misaligned=0`, `cache_address=0`.
- **Reset mid-operation:** the transaction is abandoned. A pending WRITE never issues because `cache_op_type` decodes from state.

## Timing
- Accept at edge T.
  - Load: READ in T..T+1; `o_valid` high in cycle T+2.
  - SW: WRITE in T..T+1; `o_valid` in cycle T+2.
  - SB/SH: READ, then WRITE, then `o_valid` in cycle T+3.
  - Dropped/misaligned: `o_valid` in cycle T+1.
- `o_valid` is high for exactly one cycle. `o_ready` returns the cycle after RESP. Maximum throughput is one transaction per 3 cycles (loads).
- `i_valid` while not ready is ignored. No queuing; the requester holds its request.
- The cache write is a single cycle; address and data are stable throughout WRITE.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN` controls misalignment handling. Misaligned means halfword with `addr[0]=1`, or word with `addr[1:0]!=0`.
- Defined:
  - No cache access.
  - IDLE → RESP directly.
  - `o_misaligned=1`, `o_load_val=0`.
- Undefined:
  - `o_misaligned` is tied to 0.
  - Low address bits below the access size are ignored: halfword uses `addr[1]`, word uses the aligned word.

## Structure
- Shared package `lsu_pkg` holds:
  - the state encoding (2-bit constants);
  - funct3 width constants;
  - the op constants (`OP_LOAD`/`OP_STORE`).
- Sub-module `lsu_align` (combinational) does lane extract/extend and merge. It takes `funct3`, `addr[1:0]`, `word` and `store_val`, and outputs `load_val` and `merged`.

## Test plan
- LW at 0x..10, cache word 0x8899AABB → `o_valid` at T+2, `o_load_val=0x8899AABB`, `o_rd` echoed, no cycle with `cache_op_type=1`.
- LB at 0x..11, word 0x8899AABB → `0xFFFFFFAA`. LBU at the same address → `0x000000AA`. LHU at 0x..12 → `0x00008899`.
- SB of 0x5A at 0x..13, word 0x11223344 → exactly one WRITE cycle at T+2 with `cache_i_val=0x5A223344`, `o_valid` at T+3.
- SW 0xDEADBEEF at 0x..20 → WRITE in the cycle after accept with `cache_i_val=0xDEADBEEF`. A subsequent LW returns 0xDEADBEEF.
- With `LSU_MISALIGN_TRAP_EN`: LW at 0x..22 → `o_valid` at T+1 with `o_misaligned=1`, `o_load_val=0`, no cache write. Without the macro: returns the word at 0x..20.
- Assert `rst` low during the READ of an SH → next cycle state is IDLE, `o_ready=1`, no write ever issued, all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding, width codes and decode helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have the signed width codes; loads add the unsigned variants.
    function automatic logic f3_supported(input logic op, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (op == OP_LOAD) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Only meaningful for supported codes: bits [1:0] select byte/half/word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/half lane extraction with extension, and sub-word store merge
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    input  logic [31:0] store_val,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed byte and half; half lane ignores addr[0].
    always_comb begin
        byte_lane = word[7:0];
        case (addr)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane according to the load width code.
    always_comb begin
        load_val = 32'h0;
        case (funct3)
            F3_B:    load_val = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    load_val = {{16{half_lane[15]}}, half_lane};
            F3_W:    load_val = word;
            F3_BU:   load_val = {24'h0, byte_lane};
            F3_HU:   load_val = {16'h0, half_lane};
            default: load_val = 32'h0;
        endcase
    end

    // Overlay the store data onto the old word; SW replaces the whole word.
    always_comb begin
        merged = word;
        case (funct3)
            F3_B: begin
                case (addr)
                    2'd0:    merged[7:0]   = store_val[7:0];
                    2'd1:    merged[15:8]  = store_val[7:0];
                    2'd2:    merged[23:16] = store_val[7:0];
                    default: merged[31:24] = store_val[7:0];
                endcase
            end
            F3_H: begin
                if (addr[1]) merged[31:16] = store_val[15:0];
                else         merged[15:0]  = store_val[15:0];
            end
            F3_W:    merged = store_val;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage driving data_cache; LSU_MISALIGN_TRAP_EN enables misalignment trapping
`ifndef _DATA_CACHE_OFFSET
`define _DATA_CACHE_OFFSET 32'h0000_0000
`endif

import lsu_pkg::*;

module load_store_unit #(
    parameter logic [31:0] CACHE_OFFSET = `_DATA_CACHE_OFFSET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_op,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_address,
    input  logic [31:0] i_store_val,
    input  logic [4:0]  i_rd,
    output logic        o_valid,
    output logic [31:0] o_load_val,
    output logic [4:0]  o_rd,
    output logic        o_misaligned,
    output logic [31:0] cache_address,
    output logic [31:0] cache_i_val,
    output logic        cache_op_type,
    input  logic [31:0] cache_o_val
);

    lsu_state_t  state;
    logic        op_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic [31:0] word_q;

    logic [31:0] align_word;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        trap;

    // The window base is informational only; addresses go to the cache untranslated.
    logic [31:0] unused_cache_offset;
    assign unused_cache_offset = CACHE_OFFSET;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(i_funct3, i_address[1:0]);
`else
    assign trap = 1'b0;
`endif

    // During READ extract straight from the cache so the result registers on the READ->RESP edge.
    assign align_word = (state == ST_READ) ? cache_o_val : word_q;

    lsu_align u_align (
        .funct3    (f3_q),
        .addr      (addr_q[1:0]),
        .word      (align_word),
        .store_val (store_q),
        .load_val  (load_val),
        .merged    (merged)
    );

    // Write strobe and data decode from state so an abandoned transaction can never write.
    assign o_ready       = (state == ST_IDLE);
    assign cache_address = {addr_q[31:2], 2'b00};
    assign cache_op_type = (state == ST_WRITE);
    assign cache_i_val   = (state == ST_WRITE) ? merged : 32'h0;

    // Transaction FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            op_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= 32'h0;
            store_q      <= 32'h0;
            word_q       <= 32'h0;
            o_valid      <= 1'b0;
            o_load_val   <= 32'h0;
            o_rd         <= 5'd0;
            o_misaligned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        op_q    <= i_op;
                        f3_q    <= i_funct3;
                        addr_q  <= i_address;
                        store_q <= i_store_val;
                        o_rd    <= i_rd;
                        if (!f3_supported(i_op, i_funct3) || trap) begin
                            state        <= ST_RESP;
                            o_valid      <= 1'b1;
                            o_load_val   <= 32'h0;
                            o_misaligned <= f3_supported(i_op, i_funct3) && trap;
                        end else if (i_op == OP_STORE && i_funct3 == F3_W) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    word_q <= cache_o_val;
                    if (op_q == OP_LOAD) begin
                        state        <= ST_RESP;
                        o_valid      <= 1'b1;
                        o_load_val   <= load_val;
                        o_misaligned <= 1'b0;
                    end else begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    state        <= ST_RESP;
                    o_valid      <= 1'b1;
                    o_load_val   <= 32'h0;
                    o_misaligned <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a word-array cache model
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_op = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_address = 32'h0;
    logic [31:0] i_store_val = 32'h0;
    logic [4:0]  i_rd = 5'd0;
    logic        o_valid;
    logic [31:0] o_load_val;
    logic [4:0]  o_rd;
    logic        o_misaligned;
    logic [31:0] cache_address;
    logic [31:0] cache_i_val;
    logic        cache_op_type;
    logic [31:0] cache_o_val;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:15];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_data = 32'h0;
    int          total_writes = 0;

    int          r_lat, r_wn, r_wlat;
    logic [31:0] r_val, r_wval;
    logic        r_mis, r_after_valid, r_after_ready;
    logic [4:0]  r_rd;

    always #5 clk = ~clk;

    load_store_unit #(.CACHE_OFFSET(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_op          (i_op),
        .i_funct3      (i_funct3),
        .i_address     (i_address),
        .i_store_val   (i_store_val),
        .i_rd          (i_rd),
        .o_valid       (o_valid),
        .o_load_val    (o_load_val),
        .o_rd          (o_rd),
        .o_misaligned  (o_misaligned),
        .cache_address (cache_address),
        .cache_i_val   (cache_i_val),
        .cache_op_type (cache_op_type),
        .cache_o_val   (cache_o_val)
    );

    assign cache_o_val = mem[cache_address[5:2]];

    always @(posedge clk) begin
        if (cache_op_type) begin
            mem[cache_address[5:2]] <= cache_i_val;
            total_writes <= total_writes + 1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request and record response latency (in edges after accept) and any write cycle.
    task automatic run_req(input logic op, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sv, input logic [4:0] rd);
        r_lat = 0; r_wn = 0; r_wlat = 0; r_wval = 32'h0; r_val = 32'hxxxxxxxx; r_mis = 1'bx; r_rd = 5'bx;
        @(negedge clk);
        i_valid = 1'b1; i_op = op; i_funct3 = f3; i_address = addr; i_store_val = sv; i_rd = rd;
        @(posedge clk);
        #1 i_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (cache_op_type) begin r_wn++; r_wlat = k; r_wval = cache_i_val; end
            if (o_valid) begin r_lat = k; r_val = o_load_val; r_mis = o_misaligned; r_rd = o_rd; break; end
        end
        @(negedge clk);
        r_after_valid = o_valid;
        r_after_ready = o_ready;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
        checks++; if (o_load_val !== 32'h0 || o_rd !== 5'd0 || o_misaligned !== 1'b0)
            begin failures++; $display("FAIL rst_outs got=%h/%0d/%b exp=0", o_load_val, o_rd, o_misaligned); end
        checks++; if (cache_address !== 32'h0 || cache_op_type !== 1'b0 || cache_i_val !== 32'h0)
            begin failures++; $display("FAIL rst_cache got=%h/%b/%h exp=0", cache_address, cache_op_type, cache_i_val); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_load;
        preload(4'd4, 32'h8899AABB);
        run_req(1'b0, 3'b010, BASE + 32'h10, 32'h0, 5'd7);
        checks++; if (r_lat !== 2) begin failures++; $display("FAIL lw_lat got=%0d exp=2", r_lat); end
        checks++; if (r_val !== 32'h8899AABB) begin failures++; $display("FAIL lw_val got=%h exp=8899aabb", r_val); end
        checks++; if (r_rd !== 5'd7) begin failures++; $display("FAIL lw_rd got=%0d exp=7", r_rd); end
        checks++; if (r_wn !== 0) begin failures++; $display("FAIL lw_nowrite got=%0d exp=0", r_wn); end
        checks++; if (r_after_valid !== 1'b0 || r_after_ready !== 1'b1)
            begin failures++; $display("FAIL lw_pulse got=%b/%b exp=0/1", r_after_valid, r_after_ready); end
        run_req(1'b0, 3'b000, BASE + 32'h11, 32'h0, 5'd1);
        checks++; if (r_val !== 32'hFFFFFFAA) begin failures++; $display("FAIL lb_val got=%h exp=ffffffaa", r_val); end
        run_req(1'b0, 3'b100, BASE + 32'h11, 32'h0, 5'd2);
        checks++; if (r_val !== 32'h000000AA) begin failures++; $display("FAIL lbu_val got=%h exp=000000aa", r_val); end
        run_req(1'b0, 3'b101, BASE + 32'h12, 32'h0, 5'd3);
        checks++; if (r_val !== 32'h00008899) begin failures++; $display("FAIL lhu_val got=%h exp=00008899", r_val); end
        run_req(1'b0, 3'b001, BASE + 32'h12, 32'h0, 5'd4);
        checks++; if (r_val !== 32'hFFFF8899) begin failures++; $display("FAIL lh_val got=%h exp=ffff8899", r_val); end
        run_req(1'b0, 3'b000, BASE + 32'h13, 32'h0, 5'd5);
        checks++; if (r_val !== 32'hFFFFFF88) begin failures++; $display("FAIL lb3_val got=%h exp=ffffff88", r_val); end
        run_req(1'b0, 3'b100, BASE + 32'h10, 32'h0, 5'd6);
        checks++; if (r_val !== 32'h000000BB) begin failures++; $display("FAIL lbu0_val got=%h exp=000000bb", r_val); end
    endtask

    task automatic test_store_sub;
        preload(4'd4, 32'h11223344);
        run_req(1'b1, 3'b000, BASE + 32'h13, 32'hFFFFFF5A, 5'd9);
        checks++; if (r_wn !== 1 || r_wlat !== 2) begin failures++; $display("FAIL sb_write got=n%0d@%0d exp=n1@2", r_wn, r_wlat); end
        checks++; if (r_wval !== 32'h5A223344) begin failures++; $display("FAIL sb_data got=%h exp=5a223344", r_wval); end
        checks++; if (r_lat !== 3) begin failures++; $display("FAIL sb_lat got=%0d exp=3", r_lat); end
        checks++; if (r_val !== 32'h0) begin failures++; $display("FAIL sb_loadval got=%h exp=0", r_val); end
        run_req(1'b1, 3'b001, BASE + 32'h10, 32'h1234CAFE, 5'd10);
        checks++; if (r_wval !== 32'h5A22CAFE) begin failures++; $display("FAIL sh_data got=%h exp=5a22cafe", r_wval); end
        run_req(1'b0, 3'b010, BASE + 32'h10, 32'h0, 5'd11);
        checks++; if (r_val !== 32'h5A22CAFE) begin failures++; $display("FAIL sub_readback got=%h exp=5a22cafe", r_val); end
    endtask

    task automatic test_sw;
        run_req(1'b1, 3'b010, BASE + 32'h20, 32'hDEADBEEF, 5'd12);
        checks++; if (r_wn !== 1 || r_wlat !== 1) begin failures++; $display("FAIL sw_write got=n%0d@%0d exp=n1@1", r_wn, r_wlat); end
        checks++; if (r_wval !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_data got=%h exp=deadbeef", r_wval); end
        checks++; if (r_lat !== 2) begin failures++; $display("FAIL sw_lat got=%0d exp=2", r_lat); end
        run_req(1'b0, 3'b010, BASE + 32'h20, 32'h0, 5'd13);
        checks++; if (r_val !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_readback got=%h exp=deadbeef", r_val); end
    endtask

    task automatic test_misalign;
        run_req(1'b0, 3'b010, BASE + 32'h22, 32'h0, 5'd14);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (r_lat !== 1) begin failures++; $display("FAIL mis_lat got=%0d exp=1", r_lat); end
        checks++; if (r_mis !== 1'b1 || r_val !== 32'h0) begin failures++; $display("FAIL mis_flag got=%b/%h exp=1/0", r_mis, r_val); end
        checks++; if (r_wn !== 0) begin failures++; $display("FAIL mis_nowrite got=%0d exp=0", r_wn); end
`else
        checks++; if (r_lat !== 2) begin failures++; $display("FAIL mis_lat got=%0d exp=2", r_lat); end
        checks++; if (r_mis !== 1'b0 || r_val !== 32'hDEADBEEF) begin failures++; $display("FAIL mis_word got=%b/%h exp=0/deadbeef", r_mis, r_val); end
        run_req(1'b0, 3'b001, BASE + 32'h21, 32'h0, 5'd15);
        checks++; if (r_val !== 32'hFFFFBEEF) begin failures++; $display("FAIL mis_half got=%h exp=ffffbeef", r_val); end
`endif
    endtask

    task automatic test_unsupported;
        run_req(1'b0, 3'b011, BASE + 32'h20, 32'h0, 5'd16);
        checks++; if (r_lat !== 1 || r_val !== 32'h0 || r_mis !== 1'b0)
            begin failures++; $display("FAIL bad_load got=%0d/%h/%b exp=1/0/0", r_lat, r_val, r_mis); end
        run_req(1'b1, 3'b011, BASE + 32'h20, 32'h12345678, 5'd17);
        checks++; if (r_lat !== 1 || r_wn !== 0) begin failures++; $display("FAIL bad_store got=%0d/n%0d exp=1/n0", r_lat, r_wn); end
        checks++; if (r_rd !== 5'd17) begin failures++; $display("FAIL bad_rd got=%0d exp=17", r_rd); end
    endtask

    task automatic test_reset_mid;
        int writes_before;
        preload(4'd6, 32'hA5A5A5A5);
        writes_before = total_writes;
        @(negedge clk);
        i_valid = 1'b1; i_op = 1'b1; i_funct3 = 3'b001; i_address = BASE + 32'h18; i_store_val = 32'h0000FFFF; i_rd = 5'd20;
        @(posedge clk);
        #1 i_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL mid_ctrl got=%b/%b exp=1/0", o_ready, o_valid); end
        checks++; if (o_load_val !== 32'h0 || o_rd !== 5'd0 || o_misaligned !== 1'b0 || cache_address !== 32'h0 || cache_op_type !== 1'b0 || cache_i_val !== 32'h0)
            begin failures++; $display("FAIL mid_outs got=%h/%0d/%b/%h/%b/%h exp=all0", o_load_val, o_rd, o_misaligned, cache_address, cache_op_type, cache_i_val); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (total_writes !== writes_before) begin failures++; $display("FAIL mid_nowrite got=%0d exp=%0d", total_writes, writes_before); end
        checks++; if (mem[6] !== 32'hA5A5A5A5) begin failures++; $display("FAIL mid_mem got=%h exp=a5a5a5a5", mem[6]); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset;
        test_load;
        test_store_sub;
        test_sw;
        test_misalign;
        test_unsupported;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
